// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller: Moore FSM + ALU decoder for the multicycle MIPS-subset
// CPU. Optional macro BNE_EN adds bne (op 6'h05) through a BNEEX state.
// Revision: 1.0
// ============================================================================
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef BNE_EN
    S_BNEEX   = 4'd12,
`endif
    S_JEX     = 4'd11
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
`ifdef BNE_EN
  logic       nbranch;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:   state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      // op is re-sampled here; anything other than lw/sw aborts to FETCH
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
`ifdef BNE_EN
    nbranch  = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        aluop   = 2'b01;
      end
`ifdef BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        nbranch = 1'b1;
        aluop   = 2'b01;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BNE_EN
  assign pcen = pcwrite | (branch & zero) | (nbranch & ~zero);
`else
  assign pcen = pcwrite | (branch & zero);
`endif

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'h20:   alucontrol = 3'b010;
          6'h22:   alucontrol = 3'b110;
          6'h24:   alucontrol = 3'b000;
          6'h25:   alucontrol = 3'b001;
          6'h2a:   alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// Revision: 1.0
// ============================================================================
module tb_multicycle_controller;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_REX = 6, ST_RWB = 7,
                 ST_BEQ = 8, ST_AEX = 9, ST_AWB = 10, ST_JEX = 11, ST_BNE = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [14:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
  assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  task automatic check_val(input string tag, input logic [14:0] got, input logic [14:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, expv);
    end
  endtask

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [14:0] model(input int st, input logic [5:0] f, input logic z);
    case (st)
      ST_FETCH:  return {8'b1010_0000, 2'b01, 2'b00, 3'b010};
      ST_DECODE: return {8'b0000_0000, 2'b11, 2'b00, 3'b010};
      ST_MEMADR: return {8'b0000_1000, 2'b10, 2'b00, 3'b010};
      ST_MEMRD:  return {8'b0000_0100, 2'b00, 2'b00, 3'b010};
      ST_MEMWB:  return {8'b0001_0010, 2'b00, 2'b00, 3'b010};
      ST_MEMWR:  return {8'b0100_0100, 2'b00, 2'b00, 3'b010};
      ST_REX:    return {8'b0000_1000, 2'b00, 2'b00, rtype_alu(f)};
      ST_RWB:    return {8'b0001_0001, 2'b00, 2'b00, 3'b010};
      ST_BEQ:    return {z,  7'b000_1000, 2'b00, 2'b01, 3'b110};
      ST_BNE:    return {~z, 7'b000_1000, 2'b00, 2'b01, 3'b110};
      ST_AEX:    return {8'b0000_1000, 2'b10, 2'b00, 3'b010};
      ST_AWB:    return {8'b0001_0000, 2'b00, 2'b00, 3'b010};
      ST_JEX:    return {8'b1000_0000, 2'b00, 2'b10, 3'b010};
      default:   return 15'h0;
    endcase
  endfunction

  function automatic void build_seq(input logic [5:0] o, output int seq[$]);
    seq = '{ST_FETCH, ST_DECODE};
    case (o)
      6'h00: seq = '{ST_FETCH, ST_DECODE, ST_REX, ST_RWB};
      6'h23: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};
      6'h2b: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
      6'h04: seq = '{ST_FETCH, ST_DECODE, ST_BEQ};
      6'h08: seq = '{ST_FETCH, ST_DECODE, ST_AEX, ST_AWB};
      6'h02: seq = '{ST_FETCH, ST_DECODE, ST_JEX};
`ifdef BNE_EN
      6'h05: seq = '{ST_FETCH, ST_DECODE, ST_BNE};
`endif
      default: ;
    endcase
  endfunction

  // Entered just after a posedge with the DUT in FETCH; leaves it the same way.
  // abort_idx >= 0 asserts reset right after that cycle's check.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int abort_idx);
    int seq[$];
    logic [14:0] e;
    op = o; funct = f; zero = z;
    build_seq(o, seq);
    foreach (seq[i]) exp_q.push_back(model(seq[i], f, z));
    foreach (seq[i]) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_val($sformatf("%s cyc%0d", name, i + 1), obs, e);
      if (i == abort_idx) begin
        reset = 1'b0;
        #1;
        check_val($sformatf("%s async_rst", name), obs, model(ST_FETCH, f, z));
        exp_q.delete();
        @(posedge clk); #1;
        check_val($sformatf("%s rst_hold", name), obs, model(ST_FETCH, f, z));
        reset = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3;
    check_val("reset_fetch", obs, model(ST_FETCH, 6'h20, 1'b0));
    @(posedge clk); @(posedge clk); #1;
    check_val("reset_held", obs, model(ST_FETCH, 6'h20, 1'b0));
    reset = 1'b1;

    run_instr("add",  6'h00, 6'h20, 1'b0, -1);
    run_instr("sub",  6'h00, 6'h22, 1'b0, -1);
    run_instr("and",  6'h00, 6'h24, 1'b1, -1);
    run_instr("or",   6'h00, 6'h25, 1'b0, -1);
    run_instr("slt",  6'h00, 6'h2a, 1'b0, -1);
    run_instr("rfun", 6'h00, 6'h3f, 1'b0, -1);
    run_instr("beqT", 6'h04, 6'h00, 1'b1, -1);
    run_instr("beqF", 6'h04, 6'h00, 1'b0, -1);
    run_instr("lw",   6'h23, 6'h00, 1'b0, -1);
    run_instr("sw",   6'h2b, 6'h00, 1'b1, -1);
    run_instr("addi", 6'h08, 6'h22, 1'b0, -1);
    run_instr("j",    6'h02, 6'h00, 1'b0, -1);
    run_instr("unk",  6'h3f, 6'h00, 1'b0, -1);
    run_instr("op05", 6'h05, 6'h00, 1'b1, -1);
    run_instr("lwab", 6'h23, 6'h00, 1'b0, 3);
    run_instr("post", 6'h00, 6'h25, 1'b0, -1);

    @(negedge clk);
    check_val("final_fetch", obs, model(ST_FETCH, funct, zero));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
